// File: rtl/full_adder_pkg.sv
// Shared helpers for the ripple-carry adder: width limit and the carry-majority function.
package full_adder_pkg;

    localparam int FA_WIDTH_MAX = 64;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full-adder cell; the ripple chain is built from these.
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with carry-out and signed-overflow flags.
// An optional output register stage is enabled by OUT_REG.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_comb;
    logic             co_comb;
    logic             ov_comb;

    if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_bad_width
        $error("full_adder: WIDTH out of range");
    end

    assign c[0] = CarryIn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum_comb[i]),
            .cout (c[i+1])
        );
    end

    // For WIDTH=1, c[0] (CarryIn) is the carry into the MSB.
    assign co_comb = c[WIDTH];
    assign ov_comb = c[WIDTH-1] ^ c[WIDTH];

    if (OUT_REG) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                Sum      <= '0;
                CarryOut <= 1'b0;
                Overflow <= 1'b0;
            end else begin
                Sum      <= sum_comb;
                CarryOut <= co_comb;
                Overflow <= ov_comb;
            end
        end
    end else begin : g_comb
        // Clock and reset are not used by the purely combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign Sum      = sum_comb;
        assign CarryOut = co_comb;
        assign Overflow = ov_comb;
    end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: 1-bit comb, 8-bit comb and 8-bit registered builds.
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic       a1, b1, c1;
    logic [0:0] s1;
    logic       co1, ov1;
    logic [7:0] a8, b8, s8;
    logic       c8, co8, ov8;
    logic [7:0] ar, br, sr;
    logic       cr, cor, ovr, rst_r;
    logic       rst_tie = 1'b1;

    full_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_tie), .a(a1), .b(b1), .CarryIn(c1),
        .Sum(s1), .CarryOut(co1), .Overflow(ov1));

    full_adder #(.WIDTH(8), .OUT_REG(1'b0)) u_w8 (
        .clk(clk), .rst_n(rst_tie), .a(a8), .b(b8), .CarryIn(c8),
        .Sum(s8), .CarryOut(co8), .Overflow(ov8));

    full_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_r8 (
        .clk(clk), .rst_n(rst_r), .a(ar), .b(br), .CarryIn(cr),
        .Sum(sr), .CarryOut(cor), .Overflow(ovr));

    typedef struct {
        int         due;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t qr[$];

    // Reference: plain integer arithmetic, unsigned for Sum/CarryOut, signed range for Overflow.
    function automatic exp_t ref_add(int w, logic [7:0] a, logic [7:0] b, logic cin, int due);
        exp_t   e;
        longint full, sa, sb, ss, half, modv;
        modv  = longint'(1) << w;
        half  = modv / 2;
        full  = longint'(a) + longint'(b) + longint'(cin);
        e.due = due;
        e.s   = 8'(full % modv);
        e.co  = (full >= modv);
        sa    = (longint'(a) >= half) ? longint'(a) - modv : longint'(a);
        sb    = (longint'(b) >= half) ? longint'(b) - modv : longint'(b);
        ss    = sa + sb + longint'(cin);
        e.ov  = (ss < -half) || (ss > half - 1);
        return e;
    endfunction

    function automatic void check(string name, exp_t e, logic [7:0] s, logic co, logic ov);
        tests++;
        if (e.due != cyc || s !== e.s || co !== e.co || ov !== e.ov) begin
            fails++;
            $display("FAIL %s cyc=%0d due=%0d: got Sum=%h CarryOut=%b Overflow=%b, want Sum=%h CarryOut=%b Overflow=%b",
                     name, cyc, e.due, s, co, ov, e.s, e.co, e.ov);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            check("w1_comb", e, {7'b0, s1}, co1, ov1);
        end
        while (q8.size() > 0 && q8[0].due <= cyc) begin
            e = q8.pop_front();
            check("w8_comb", e, s8, co8, ov8);
        end
        while (qr.size() > 0 && qr[0].due <= cyc) begin
            e = qr.pop_front();
            check("w8_reg", e, sr, cor, ovr);
        end
    end

    task automatic rnd_all();
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        ar = 8'($urandom); br = 8'($urandom); cr = 1'($urandom);
    endtask

    // Record expectations for the currently driven inputs, then advance one cycle.
    task automatic step();
        exp_t z;
        q1.push_back(ref_add(1, {7'b0, a1}, {7'b0, b1}, c1, cyc));
        q8.push_back(ref_add(8, a8, b8, c8, cyc));
        if (!rst_r) begin
            z.due = cyc + 1; z.s = 8'h00; z.co = 1'b0; z.ov = 1'b0;
            qr.push_back(z);
        end else begin
            qr.push_back(ref_add(8, ar, br, cr, cyc + 1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_r = 1'b0;
        rnd_all();
        @(posedge clk);
        #1;

        // Registered build held in reset for two edges, then released.
        rnd_all(); rst_r = 1'b0; step();
        rnd_all(); rst_r = 1'b0; step();
        rnd_all(); rst_r = 1'b1; ar = 8'h12; br = 8'h34; cr = 1'b1; step();

        // Exhaustive 1-bit sweep.
        for (int i = 0; i < 8; i++) begin
            rnd_all();
            {a1, b1, c1} = 3'(i);
            step();
        end

        // Overflow and wrap-around corners.
        rnd_all(); {a1, b1, c1} = 3'b110; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; step();
        rnd_all(); {a1, b1, c1} = 3'b001; a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; step();
        rnd_all(); {a1, b1, c1} = 3'b101; ar = 8'hFF; br = 8'h00; cr = 1'b1; step();
        rnd_all(); ar = 8'h80; br = 8'h80; cr = 1'b0; a8 = 8'h80; b8 = 8'hFF; c8 = 1'b0; step();

        // Mid-stream single-edge reset with inputs still changing.
        for (int i = 0; i < 5; i++) begin rnd_all(); step(); end
        rnd_all(); rst_r = 1'b0; step();
        rst_r = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rnd_all();
            if ($urandom_range(0, 19) == 0) rst_r = 1'b0; else rst_r = 1'b1;
            step();
        end
        rst_r = 1'b1;

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        if (q1.size() + q8.size() + qr.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q1.size() + q8.size() + qr.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
